// File: rtl/cond_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// cond_exec_stage_pkg
// Shared CPU definitions for the conditional-execute stage:
//   - cond_e        : 4-bit instruction condition field encoding (EQ..AL, NV)
//   - FLAG_*        : bit positions of N, Z, C, V inside the flag register
//   - FW_*          : FlagWriteE encodings (which flag pairs an op updates)
// -----------------------------------------------------------------------------
package cond_exec_stage_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWriteE bit positions and the resulting encodings
    localparam int FW_NZ_BIT = 1;
    localparam int FW_CV_BIT = 0;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// -----------------------------------------------------------------------------
// cond_exec_stage_cond_check
// Purely combinational condition evaluator.
// Ports:
//   CondE     in  4  instruction condition field (cond_e encoding)
//   FlagsQ    in  4  current flags [N,Z,C,V]
//   cond_pass out 1  condition holds for the given flags (NV never passes)
// -----------------------------------------------------------------------------
module cond_exec_stage_cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsQ,
    output logic       cond_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = FlagsQ[FLAG_N];
    assign w_z = FlagsQ[FLAG_Z];
    assign w_c = FlagsQ[FLAG_C];
    assign w_v = FlagsQ[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e'(CondE))
            COND_EQ: cond_pass = w_z;
            COND_NE: cond_pass = !w_z;
            COND_CS: cond_pass = w_c;
            COND_CC: cond_pass = !w_c;
            COND_MI: cond_pass = w_n;
            COND_PL: cond_pass = !w_n;
            COND_VS: cond_pass = w_v;
            COND_VC: cond_pass = !w_v;
            COND_HI: cond_pass = w_c && !w_z;
            COND_LS: cond_pass = !w_c || w_z;
            COND_GE: cond_pass = (w_n == w_v);
            COND_LT: cond_pass = (w_n != w_v);
            COND_GT: cond_pass = !w_z && (w_n == w_v);
            COND_LE: cond_pass = w_z || (w_n != w_v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;   // NV: reserved, never executes
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// -----------------------------------------------------------------------------
// cond_exec_stage
// Sits behind the execute-stage ALU. Holds the NZCV flag register, evaluates
// the Execute instruction's condition field against it, gates the
// instruction's register/memory/branch side effects and latches the result
// into the EX/MEM pipeline register (flush > stall > load).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ValidE, KillE              Execute holds a real / squashed instruction
//   CondE, FlagWriteE, FlagsE  condition field, flag-pair write enables, ALU flags
//   ResultE, WriteDataE        ALU result, store data
//   RegWriteE, MemWriteE, BranchE, WriteRegE  instruction control
//   StallM, FlushM             EX/MEM hold / bubble insertion
//   CondExE, BranchTakenE      combinational condition pass / taken branch
//   FlagsQ                     current flag register
//   ValidM, RegWriteM, MemWriteM, ResultM, WriteDataM, WriteRegM  EX/MEM register
// -----------------------------------------------------------------------------
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter int         REG_ADDR_W = 4,
    parameter logic [3:0] FLAGS_RST  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidE,
    input  logic                  KillE,
    input  logic [3:0]            CondE,
    input  logic [1:0]            FlagWriteE,
    input  logic [DATA_W-1:0]     ResultE,
    input  logic [3:0]            FlagsE,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  BranchE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [DATA_W-1:0]     WriteDataE,
    input  logic                  StallM,
    input  logic                  FlushM,
    output logic                  CondExE,
    output logic                  BranchTakenE,
    output logic [3:0]            FlagsQ,
    output logic                  ValidM,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [DATA_W-1:0]     ResultM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [REG_ADDR_W-1:0] WriteRegM
);

    logic                  w_cond_pass;
    logic                  w_live;
    logic                  w_flag_we;

    logic [3:0]            r_flags;
    logic                  r_valid;
    logic                  r_reg_write;
    logic                  r_mem_write;
    logic [DATA_W-1:0]     r_result;
    logic [DATA_W-1:0]     r_write_data;
    logic [REG_ADDR_W-1:0] r_write_reg;

    cond_exec_stage_cond_check u_cond_check (
        .CondE     (CondE),
        .FlagsQ    (r_flags),
        .cond_pass (w_cond_pass)
    );

    // A killed instruction is a bubble: it neither passes its condition nor
    // reaches MEM as live.
    assign w_live       = ValidE && !KillE;
    assign CondExE      = w_live && w_cond_pass;
    assign BranchTakenE = BranchE && CondExE;

    // Flags are frozen by StallM even when a flush wins the EX/MEM register.
    assign w_flag_we = CondExE && !StallM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= FLAGS_RST;
        end else if (w_flag_we) begin
            if (FlagWriteE[FW_NZ_BIT]) begin
                r_flags[FLAG_N] <= FlagsE[FLAG_N];
                r_flags[FLAG_Z] <= FlagsE[FLAG_Z];
            end
            if (FlagWriteE[FW_CV_BIT]) begin
                r_flags[FLAG_C] <= FlagsE[FLAG_C];
                r_flags[FLAG_V] <= FlagsE[FLAG_V];
            end
        end
    end

    // EX/MEM register. A flush only kills the control bits; the data fields
    // are don't-care once ValidM is low, so they simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result     <= '0;
            r_write_data <= '0;
            r_write_reg  <= '0;
        end else if (FlushM) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!StallM) begin
            r_valid      <= w_live;
            r_reg_write  <= RegWriteE && CondExE;
            r_mem_write  <= MemWriteE && CondExE;
            r_result     <= ResultE;
            r_write_data <= WriteDataE;
            r_write_reg  <= WriteRegE;
        end
    end

    assign FlagsQ     = r_flags;
    assign ValidM     = r_valid;
    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultM    = r_result;
    assign WriteDataM = r_write_data;
    assign WriteRegM  = r_write_reg;

endmodule

// File: tb/tb_cond_exec_stage.sv
module tb_cond_exec_stage;
    import cond_exec_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ValidE;
    logic        KillE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [31:0] ResultE;
    logic [3:0]  FlagsE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        BranchE;
    logic [3:0]  WriteRegE;
    logic [31:0] WriteDataE;
    logic        StallM;
    logic        FlushM;
    logic        CondExE;
    logic        BranchTakenE;
    logic [3:0]  FlagsQ;
    logic        ValidM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [31:0] ResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  WriteRegM;

    int n_cmp;
    int n_fail;

    cond_exec_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (4),
        .FLAGS_RST  (4'b0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ValidE       (ValidE),
        .KillE        (KillE),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .ResultE      (ResultE),
        .FlagsE       (FlagsE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .WriteRegE    (WriteRegE),
        .WriteDataE   (WriteDataE),
        .StallM       (StallM),
        .FlushM       (FlushM),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .FlagsQ       (FlagsQ),
        .ValidM       (ValidM),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .ResultM      (ResultM),
        .WriteDataM   (WriteDataM),
        .WriteRegM    (WriteRegM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n      = 1'b0;
        ValidE     = 1'b0;
        KillE      = 1'b0;
        CondE      = COND_AL;
        FlagWriteE = FW_NONE;
        ResultE    = '0;
        FlagsE     = 4'b0000;
        RegWriteE  = 1'b0;
        MemWriteE  = 1'b0;
        BranchE    = 1'b0;
        WriteRegE  = '0;
        WriteDataE = '0;
        StallM     = 1'b0;
        FlushM     = 1'b0;

        // ---- reset state
        step();
        step();
        check("rst_flags",  {28'd0, FlagsQ}, 32'h0);
        check("rst_validm", {31'd0, ValidM}, 32'h0);
        check("rst_regwr",  {31'd0, RegWriteM}, 32'h0);
        check("rst_memwr",  {31'd0, MemWriteM}, 32'h0);
        check("rst_result", ResultM, 32'h0);
        check("rst_wdata",  WriteDataM, 32'h0);
        check("rst_wreg",   {28'd0, WriteRegM}, 32'h0);
        rst_n = 1'b1;
        step();

        // ---- AL ADD setting flags 0100
        ValidE     = 1'b1;
        CondE      = COND_AL;
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b0100;
        RegWriteE  = 1'b1;
        ResultE    = 32'h1234_5678;
        WriteRegE  = 4'd3;
        WriteDataE = 32'h0000_DEAD;
        #1 check("al_condex", {31'd0, CondExE}, 32'h1);
        step();
        check("al_flags",   {28'd0, FlagsQ}, 32'h4);
        check("al_regwr",   {31'd0, RegWriteM}, 32'h1);
        check("al_validm",  {31'd0, ValidM}, 32'h1);
        check("al_result",  ResultM, 32'h1234_5678);
        check("al_wreg",    {28'd0, WriteRegM}, 32'h3);
        check("al_wdata",   WriteDataM, 32'h0000_DEAD);
        check("al_memwr",   {31'd0, MemWriteM}, 32'h0);

        // ---- branches on Z=1
        CondE      = COND_EQ;
        BranchE    = 1'b1;
        FlagWriteE = FW_NONE;
        #1 check("beq_taken", {31'd0, BranchTakenE}, 32'h1);
        CondE      = COND_NE;
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b1111;
        #1 check("bne_taken", {31'd0, BranchTakenE}, 32'h0);
        check("bne_condex", {31'd0, CondExE}, 32'h0);
        step();
        check("bne_flags",  {28'd0, FlagsQ}, 32'h4);
        check("bne_validm", {31'd0, ValidM}, 32'h1);
        check("bne_regwr",  {31'd0, RegWriteM}, 32'h0);

        // ---- clear flags, then failing EQ store
        BranchE    = 1'b0;
        CondE      = COND_AL;
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b0000;
        step();
        check("clr_flags", {28'd0, FlagsQ}, 32'h0);
        CondE      = COND_EQ;
        RegWriteE  = 1'b0;
        MemWriteE  = 1'b1;
        FlagsE     = 4'b1000;
        step();
        check("stfail_memwr",  {31'd0, MemWriteM}, 32'h0);
        check("stfail_validm", {31'd0, ValidM}, 32'h1);
        check("stfail_flags",  {28'd0, FlagsQ}, 32'h0);

        // ---- partial flag writes
        MemWriteE  = 1'b0;
        CondE      = COND_AL;
        FlagWriteE = FW_NZ;
        FlagsE     = 4'b1111;
        step();
        check("fw_nz_flags", {28'd0, FlagsQ}, 32'hC);
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b1001;
        step();
        check("set1001", {28'd0, FlagsQ}, 32'h9);
        FlagWriteE = FW_NONE;
        CondE = COND_GE; #1 check("ge_1001", {31'd0, CondExE}, 32'h1);
        CondE = COND_LT; #1 check("lt_1001", {31'd0, CondExE}, 32'h0);
        CondE = COND_GT; #1 check("gt_1001", {31'd0, CondExE}, 32'h1);
        CondE = COND_LE; #1 check("le_1001", {31'd0, CondExE}, 32'h0);
        CondE = COND_HI; #1 check("hi_1001", {31'd0, CondExE}, 32'h0);
        CondE = COND_LS; #1 check("ls_1001", {31'd0, CondExE}, 32'h1);
        CondE = COND_NV; #1 check("nv_1001", {31'd0, CondExE}, 32'h0);
        CondE      = COND_AL;
        FlagWriteE = FW_CV;
        FlagsE     = 4'b0110;
        step();
        check("fw_cv_flags", {28'd0, FlagsQ}, 32'hA);

        // ---- killed instruction is a bubble
        KillE      = 1'b1;
        RegWriteE  = 1'b1;
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b0000;
        #1 check("kill_condex", {31'd0, CondExE}, 32'h0);
        step();
        check("kill_validm", {31'd0, ValidM}, 32'h0);
        check("kill_regwr",  {31'd0, RegWriteM}, 32'h0);
        check("kill_flags",  {28'd0, FlagsQ}, 32'hA);

        // ---- instruction A, then stalled B
        KillE      = 1'b0;
        FlagWriteE = FW_NONE;
        ResultE    = 32'hAAAA_0001;
        WriteRegE  = 4'd5;
        WriteDataE = 32'h0000_00A1;
        step();
        check("a_result", ResultM, 32'hAAAA_0001);
        check("a_regwr",  {31'd0, RegWriteM}, 32'h1);
        ResultE    = 32'hBBBB_0002;
        WriteRegE  = 4'd6;
        WriteDataE = 32'h0000_00B2;
        MemWriteE  = 1'b1;
        FlagWriteE = FW_ALL;
        FlagsE     = 4'b0101;
        StallM     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_result", ResultM, 32'hAAAA_0001);
            check("stall_wreg",   {28'd0, WriteRegM}, 32'h5);
            check("stall_wdata",  WriteDataM, 32'h0000_00A1);
            check("stall_memwr",  {31'd0, MemWriteM}, 32'h0);
            check("stall_regwr",  {31'd0, RegWriteM}, 32'h1);
            check("stall_flags",  {28'd0, FlagsQ}, 32'hA);
        end
        FlushM = 1'b1;
        step();
        check("flush_validm", {31'd0, ValidM}, 32'h0);
        check("flush_regwr",  {31'd0, RegWriteM}, 32'h0);
        check("flush_result", ResultM, 32'hAAAA_0001);
        check("flush_flags",  {28'd0, FlagsQ}, 32'hA);

        // ---- load B normally, then asynchronous reset mid-cycle
        FlushM     = 1'b0;
        StallM     = 1'b0;
        MemWriteE  = 1'b0;
        FlagWriteE = FW_NONE;
        step();
        check("b_regwr",  {31'd0, RegWriteM}, 32'h1);
        check("b_result", ResultM, 32'hBBBB_0002);
        check("b_flags",  {28'd0, FlagsQ}, 32'hA);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags",  {28'd0, FlagsQ}, 32'h0);
        check("arst_validm", {31'd0, ValidM}, 32'h0);
        check("arst_regwr",  {31'd0, RegWriteM}, 32'h0);
        check("arst_result", ResultM, 32'h0);
        check("arst_wdata",  WriteDataM, 32'h0);
        check("arst_wreg",   {28'd0, WriteRegM}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Sits directly downstream of the execute-stage ALU in the pipelined CPU.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the instruction in Execute against it.
- Gates that instruction's register-write, memory-write and branch side effects.
- Latches the ALU result and control into the EX/MEM pipeline register with stall and flush support.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_ADDR_W, 4, destination register index width
- FLAGS_RST, 4'b0000, reset value of the flag register [N,Z,C,V]

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidE  in  1  Execute stage holds a real instruction
- KillE  in  1  Execute instruction squashed (e.g. taken-branch shadow)
- CondE  in  4  instruction condition field
- FlagWriteE  in  2  bit1: update N,Z; bit0: update C,V
- ResultE  in  DATA_W  ALU result
- FlagsE  in  4  ALU flags [N,Z,C,V] (bit3..bit0)
- RegWriteE  in  1  instruction writes the register file
- MemWriteE  in  1  instruction is a store
- BranchE  in  1  instruction is a branch
- WriteRegE  in  REG_ADDR_W  destination register
- WriteDataE  in  DATA_W  store data
- StallM  in  1  hold EX/MEM register and flags
- FlushM  in  1  load bubble into EX/MEM register
- CondExE  out  1  condition passed (combinational)
- BranchTakenE  out  1  BranchE & CondExE (combinational, to fetch)
- FlagsQ  out  4  current flag register
- ValidM  out  1  EX/MEM holds a live instruction
- RegWriteM  out  1  gated register write
- MemWriteM  out  1  gated memory write
- ResultM  out  DATA_W  latched ALU result
- WriteDataM  out  DATA_W  latched store data
- WriteRegM  out  REG_ADDR_W  latched destination

Behaviour:
- Reset (async assert, sync release): FlagsQ=FLAGS_RST; ValidM, RegWriteM, MemWriteM = 0; ResultM, WriteDataM, WriteRegM = 0. Reset mid-operation discards the in-flight instruction, with no partial flag update.
- Condition check, combinational on FlagsQ. N,Z,C,V = FlagsQ[3:0].
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 reserved = never
- Gating: CondExE = ValidE & !KillE & cond_pass. BranchTakenE = BranchE & CondExE.
- Flag update, posedge, only if CondExE & !StallM:
  - FlagWriteE[1] loads FlagsQ[3:2] from FlagsE[3:2].
  - FlagWriteE[0] loads FlagsQ[1:0] from FlagsE[1:0].
  - Bits not selected are unchanged. A failed condition never updates flags.
- Latency:
  - Flags written in cycle n are visible to the instruction in Execute at cycle n+1; no bypass.
  - The EX/MEM register has 1-cycle latency.
- EX/MEM register, posedge, priority FlushM > StallM > load:
  - FlushM: ValidM, RegWriteM, MemWriteM = 0; data fields hold their value.
  - StallM (no flush): all M outputs hold.
  - Load: ValidM = ValidE & !KillE; RegWriteM = RegWriteE & CondExE; MemWriteM = MemWriteE & CondExE; data fields = E inputs.
- Conditional-fail instruction: still loaded with ValidM=1 but both write enables are 0 (a visible no-op).
- Simultaneous FlushM and StallM: the flush wins for the M register; flags are still frozen because StallM is 1.
- KillE with ValidE: behaves as a bubble (no flag update, ValidM=0 on load).
- Width rules: no arithmetic in this block. FlagsE is taken as produced by the ALU.

Decomposition:
- Shared cpu package holds:
  - cond_e enum (4-bit, EQ..AL, NV)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - flagwrite encoding constants
- One sub-module, cond_check: purely combinational; inputs CondE and FlagsQ, output cond_pass. It is reused by the verification model.
- The flag register and EX/MEM register stay in the top module.

Test Plan:
- Reset then AL ADD with FlagWriteE=11, FlagsE=0100, RegWriteE=1 -> next cycle FlagsQ=0100, RegWriteM=1, ResultM=ResultE, ValidM=1.
- FlagsQ=0100, CondE=EQ, BranchE=1 -> BranchTakenE=1; CondE=NE -> BranchTakenE=0, no flag change.
- FlagsQ=0000, CondE=EQ, MemWriteE=1, FlagWriteE=11, FlagsE=1000 -> MemWriteM=0, ValidM=1, FlagsQ stays 0000.
- FlagWriteE=10, FlagsE=1111 from FlagsQ=0000 -> FlagsQ=1100 (C,V untouched); then GE with FlagsQ=1001 -> CondExE=1.
- Load instruction A, then StallM=1 for 2 cycles with FlagWriteE=11 on incoming B -> M outputs and FlagsQ hold; FlushM with StallM -> ValidM=0, RegWriteM=0.
- Assert rst_n low asynchronously mid-cycle with RegWriteM=1, FlagsQ=1010 -> outputs zero immediately, before the next clock edge; FlagsQ=FLAGS_RST.
